// File: rtl/fifo_stim_driver_pkg.sv
// Shared types and constants for the FIFO stimulus engine: burst modes, FSM
// states and the 16-bit Fibonacci LFSR definition.
package fifo_stim_driver_pkg;

  typedef enum logic [1:0] {
    MODE_WR   = 2'd0,
    MODE_RD   = 2'd1,
    MODE_RAND = 2'd2,
    MODE_FILL = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RAND  = 3'd3,
    S_FILL  = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fifo_stim_driver_lfsr.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0. Advances one
// step per cycle while advance is high; a zero seed is forced to 1.
module fifo_lfsr16
  import fifo_stim_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d, seed_fix;

  assign seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= seed_fix;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/fifo_stim_driver.sv
// Burst stimulus engine for the synchronous FIFO: drives wr_en/rd_en/data_in in
// one of four modes and counts the FIFO's handshake/status responses.
module fifo_stim_driver
  import fifo_stim_driver_pkg::*;
#(
  parameter int          FIFO_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_ops,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  txn_valid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           ack_cnt,
  output logic [15:0]           ovf_cnt,
  output logic [15:0]           udf_cnt
);

  localparam logic [15:0] DEPTH_OPS = 16'(FIFO_DEPTH);

  state_e                state_q, state_d;
  mode_e                 mode_in;
  logic [15:0]           cnt_q, cnt_d, target_q, target_d;
  logic [15:0]           lfsr_val;
  logic                  lfsr_adv, clr_stat, count_en;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  txn_q, txn_d, busy_q, busy_d, done_q, done_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [15:0]           ack_q, ovf_q, udf_q;

  // The engine drives blindly; full/empty are only observed by the bench.
  logic unused_status;
  assign unused_status = &{1'b0, full, empty};

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic hit);
    return (hit && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  fifo_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign mode_in = mode_e'(mode);

  // Next-state: the op counter walks 0..target-1 within each drive state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    clr_stat = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_stat = 1'b1;
          cnt_d    = 16'd0;
          target_d = num_ops;
          if (mode_in == MODE_FILL) begin
            state_d  = S_FILL;
            target_d = DEPTH_OPS;
          end else if (num_ops == 16'd0) begin
            state_d = S_FIN;
          end else begin
            unique case (mode_in)
              MODE_WR: state_d = S_WR;
              MODE_RD: state_d = S_RD;
              default: state_d = S_RAND;
            endcase
          end
        end
      end
      S_WR, S_RD, S_RAND, S_FILL, S_DRAIN: begin
        if (cnt_q == target_q - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = (state_q == S_FILL) ? S_DRAIN : S_FIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered. The LFSR steps as
  // its current value is captured, so each drive cycle shows the pre-advance value.
  always_comb begin
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    data_d   = '0;
    done_d   = 1'b0;
    lfsr_adv = 1'b0;
    unique case (state_d)
      S_WR, S_FILL: begin
        wr_en_d = 1'b1;
        data_d  = FIFO_WIDTH'(cnt_d);
      end
      S_RD, S_DRAIN: rd_en_d = 1'b1;
      S_RAND: begin
        wr_en_d  = lfsr_val[0];
        rd_en_d  = lfsr_val[1];
        data_d   = FIFO_WIDTH'(lfsr_val);
        lfsr_adv = 1'b1;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
    busy_d = state_d inside {S_WR, S_RD, S_RAND, S_FILL, S_DRAIN};
    txn_d  = (state_d == S_RAND) | wr_en_d | rd_en_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      target_q <= 16'd0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      data_q   <= '0;
      txn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      data_q   <= data_d;
      txn_q    <= txn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The FIN cycle is included so the response to the last drive op is counted
  assign count_en = busy_q | (state_q == S_FIN);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stat) begin
      ack_q <= 16'd0;
      ovf_q <= 16'd0;
      udf_q <= 16'd0;
    end else if (count_en) begin
      ack_q <= sat_inc(ack_q, wr_ack);
      ovf_q <= sat_inc(ovf_q, overflow);
      udf_q <= sat_inc(udf_q, underflow);
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign data_in   = data_q;
  assign txn_valid = txn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_cnt   = ack_q;
  assign ovf_cnt   = ovf_q;
  assign udf_cnt   = udf_q;

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: a behavioural FIFO answers the drive cycles, a
// reference model queues expected drives/counts, and a monitor compares them.
module tb_fifo_stim_driver;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] data;
  } drv_t;

  typedef struct {
    int ack;
    int ovf;
    int udf;
  } cnt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [15:0]  num_ops = 16'd0;
  logic         env_full, env_empty, env_ack, env_ovf, env_udf;
  logic         wr_en, rd_en, txn_valid, busy, done;
  logic [W-1:0] data_in;
  logic [15:0]  ack_cnt, ovf_cnt, udf_cnt;

  int   n_checks = 0;
  int   n_err = 0;
  int   env_occ;
  int   m_occ = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int   busy_cnt = 0;
  int   first_data = 0;
  bit   mon_en = 1'b0;
  bit   cnt_pending = 1'b0;
  cnt_t exp_cnt;
  drv_t mon_e;
  drv_t exp_q[$];
  cnt_t exp_done_q[$];

  always #5 clk = ~clk;

  fifo_stim_driver #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .num_ops   (num_ops),
    .full      (env_full),
    .empty     (env_empty),
    .wr_ack    (env_ack),
    .overflow  (env_ovf),
    .underflow (env_udf),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .txn_valid (txn_valid),
    .busy      (busy),
    .done      (done),
    .ack_cnt   (ack_cnt),
    .ovf_cnt   (ovf_cnt),
    .udf_cnt   (udf_cnt)
  );

  // Behavioural FIFO: registered one-cycle status flags, shares the reset
  always @(posedge clk) begin
    if (!rst_n) begin
      env_occ <= 0;
      env_ack <= 1'b0;
      env_ovf <= 1'b0;
      env_udf <= 1'b0;
    end else begin
      env_ack <= wr_en && (env_occ < DEPTH);
      env_ovf <= wr_en && (env_occ >= DEPTH);
      env_udf <= rd_en && (env_occ == 0);
      env_occ <= env_occ + ((wr_en && env_occ < DEPTH) ? 1 : 0)
                         - ((rd_en && env_occ > 0) ? 1 : 0);
    end
  end
  assign env_full  = (env_occ == DEPTH);
  assign env_empty = (env_occ == 0);

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  // Reference model: expected drive list and status totals for one burst
  task automatic model_burst(input int m, input int n, output int len);
    cnt_t c;
    drv_t d;
    bit   w_ok, r_ok;
    c   = '{0, 0, 0};
    len = (m == 3) ? 2 * DEPTH : n;
    for (int i = 0; i < len; i++) begin
      d.wr = 1'b0; d.rd = 1'b0; d.data = 16'h0;
      case (m)
        0: begin d.wr = 1'b1; d.data = 16'(i); end
        1: d.rd = 1'b1;
        2: begin
          d.wr = m_lfsr[0]; d.rd = m_lfsr[1]; d.data = m_lfsr;
          m_lfsr = ref_lfsr_next(m_lfsr);
        end
        default: begin
          if (i < DEPTH) begin d.wr = 1'b1; d.data = 16'(i); end
          else d.rd = 1'b1;
        end
      endcase
      exp_q.push_back(d);
      w_ok = d.wr && (m_occ < DEPTH);
      r_ok = d.rd && (m_occ > 0);
      c.ack += w_ok ? 1 : 0;
      c.ovf += (d.wr && !w_ok) ? 1 : 0;
      c.udf += (d.rd && !r_ok) ? 1 : 0;
      m_occ += (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
    end
    exp_done_q.push_back(c);
  endtask

  // Monitor: compare every presented drive cycle and the totals after done
  always @(negedge clk) begin
    if (mon_en) begin
      if (txn_valid) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("drv_wr", int'(wr_en), int'(mon_e.wr));
          chk("drv_rd", int'(rd_en), int'(mon_e.rd));
          chk("drv_data", int'(data_in), int'(mon_e.data));
        end
      end else begin
        chk("idle_bus", int'(wr_en | rd_en), 0);
      end
      if (cnt_pending) begin
        chk("ack_cnt", int'(ack_cnt), exp_cnt.ack);
        chk("ovf_cnt", int'(ovf_cnt), exp_cnt.ovf);
        chk("udf_cnt", int'(udf_cnt), exp_cnt.udf);
        chk("done_one_cycle", int'(done), 0);
        cnt_pending = 1'b0;
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_cnt = exp_done_q.pop_front();
          cnt_pending = 1'b1;
          chk("drives_pending", exp_q.size(), 0);
        end
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_occ  = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic run_burst(input int m, input int n, input int mid_start, input bit fin_start);
    int len;
    int c_done;
    bit got;
    model_burst(m, n, len);
    busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'(m); num_ops = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); num_ops = 16'($urandom_range(1, 30));
    got = 1'b0;
    c_done = -1;
    for (int c = 0; c < len + 8 && !got; c++) begin
      @(negedge clk);
      if (c == 0) first_data = int'(data_in);
      if (done) begin got = 1'b1; c_done = c; end
      start = (c == mid_start) || (got && fin_start);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_latency", c_done, len);
    chk("busy_cycles", busy_cnt, len);
    repeat (3) begin
      @(negedge clk);
      chk("post_idle_busy", int'(busy), 0);
      chk("post_idle_txn", int'(txn_valid), 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_data", int'(data_in), 0);
    chk("rst_txn", int'(txn_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnts", int'(ack_cnt | ovf_cnt | udf_cnt), 0);
    mon_en = 1'b1;

    run_burst(2, 12, -1, 1'b0);
    chk("rand_first_data", first_data, 32'hACE1);

    do_reset();
    run_burst(0, 10, -1, 1'b0);
    chk("wr10_ack", int'(ack_cnt), 8);
    chk("wr10_ovf", int'(ovf_cnt), 2);

    do_reset();
    run_burst(3, 0, -1, 1'b0);
    chk("fill_ack", int'(ack_cnt), 8);
    chk("fill_ovf", int'(ovf_cnt), 0);
    chk("fill_udf", int'(udf_cnt), 0);
    chk("fill_busy", busy_cnt, 16);

    run_burst(1, 3, -1, 1'b0);
    chk("rd3_udf", int'(udf_cnt), 3);
    chk("rd3_ack", int'(ack_cnt), 0);

    run_burst(0, 0, -1, 1'b0);
    run_burst(0, 6, 2, 1'b1);
    chk("ignored_start_ack", int'(ack_cnt), 6);

    // Reset during the 5th drive cycle of a 20-op write burst
    for (int i = 0; i < 5; i++) exp_q.push_back('{1'b1, 1'b0, 16'(i)});
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; num_ops = 16'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_occ  = 0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ack", int'(ack_cnt), 0);
    chk("midrst_consumed", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end
    run_burst(0, 4, -1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 14)),
                int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stim_driver.md
Name: fifo_stim_driver

Overview:
Synthesizable stimulus engine that drives the write/read side of the synchronous FIFO DUT. It is the driving counterpart to the passive monitor. On a start pulse it issues a programmed burst of wr_en/rd_en/data_in cycles in one of four modes. It also counts DUT handshake/status responses so the bench can cross-check them against the scoreboard totals.

Parameters:
FIFO_WIDTH, 16, data_in width (LFSR value zero-extended or truncated to fit)
FIFO_DEPTH, 8, DUT depth; sets the FILL_THEN_DRAIN burst length
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; a value of 0 is replaced by 16'h0001

Ports:
clk  in  1  sole clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a burst; ignored while busy=1
mode  in  2  0 WRITE_ONLY, 1 READ_ONLY, 2 RANDOM, 3 FILL_THEN_DRAIN; latched on accepted start
num_ops  in  16  number of drive cycles; latched on accepted start; ignored in mode 3
full, empty, wr_ack, overflow, underflow  in  1 each  DUT status
wr_en  out  1  FIFO write enable (registered)
rd_en  out  1  FIFO read enable (registered)
data_in  out  FIFO_WIDTH  FIFO write data (registered)
txn_valid  out  1  high on every drive cycle; the bench samples the DUT on the following negedge
busy  out  1  high from the cycle after an accepted start until the last drive cycle, inclusive
done  out  1  one-cycle pulse on the cycle after the last drive cycle
ack_cnt, ovf_cnt, udf_cnt  out  16 each  saturating counts of wr_ack/overflow/underflow since the last accepted start

Behaviour:
- Reset (rst_n=0 at a posedge): on that edge, all outputs go to 0, FSM goes to IDLE, op counter and status counters are cleared, LFSR loads the seed. Applies mid-burst; the burst is abandoned with no done pulse.
- FSM states: IDLE, WR, RD, RAND, FILL, DRAIN, FIN.
- IDLE, start=1 at edge N: latch mode/num_ops, clear status counters, enter the mode state. The first drive cycle is N+1.
- IDLE, accepted start with num_ops=0 (modes 0-2): go to FIN. There are no drive cycles, and done pulses at N+1.
- WR: wr_en=1, rd_en=0. data_in = op index (0,1,2,...) truncated to FIFO_WIDTH. Runs num_ops cycles regardless of full, so overflow is exercised deliberately.
- RD: rd_en=1, wr_en=0, data_in=0. Runs num_ops cycles regardless of empty.
- RAND: the LFSR advances once per drive cycle.
  - Polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0.
  - wr_en=lfsr[0], rd_en=lfsr[1], data_in=lfsr[FIFO_WIDTH-1:0], using the current (pre-advance) value.
  - Runs num_ops cycles.
- FILL: FIFO_DEPTH cycles of writes, data 0..DEPTH-1, then DRAIN.
- DRAIN: FIFO_DEPTH cycles of reads. Total burst is 2*FIFO_DEPTH cycles.
- Op counter: 16-bit, increments on each drive cycle. The last drive cycle is when counter == target-1. Next state is FIN.
- FIN: wr_en=rd_en=txn_valid=busy=0, done=1 for exactly one cycle, then IDLE.
- txn_valid = wr_en|rd_en in WR/RD/FILL/DRAIN. In RAND it is 1 every drive cycle, including idle-bus cycles where wr_en=rd_en=0.
- Status counters: increment when the corresponding input is 1 at a posedge while busy=1 or during the FIN cycle (catches last-op response). They saturate at 16'hFFFF and hold their value in IDLE.
- start asserted in the same cycle as done or FIN is ignored. A start is accepted only in IDLE.
- No combinational path from any input to any output.

Decomposition:
- shared package: mode enum (mode_e), FSM state enum (state_e), LFSR polynomial/tap constant, LFSR_SEED default.
- One natural sub-module: fifo_lfsr16 (clk, rst_n, seed, advance -> value).
- Status counters are written inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, counters 0; first RAND data_in after start equals 16'hACE1.
- WRITE_ONLY, num_ops=10, DEPTH=8, DUT empty -> wr_en high 10 cycles, data 0..9; ack_cnt=8, ovf_cnt=2, done one cycle after the 10th write.
- FILL_THEN_DRAIN from empty -> 8 writes (0..7) then 8 reads; ack_cnt=8, ovf_cnt=0, udf_cnt=0; busy high exactly 16 cycles.
- READ_ONLY, num_ops=3 on empty DUT -> udf_cnt=3, ack_cnt=0.
- Reset mid-burst: WRITE_ONLY num_ops=20, rst_n=0 at the 5th drive cycle -> wr_en=0 on that edge, no done pulse, counters 0; a new start afterwards runs normally.
- Edge starts: num_ops=0 -> done at N+1 with no wr_en/rd_en; start during busy -> ignored, burst length unchanged.
